// File: rtl/traffic_phase_seq.sv
// Timed green/yellow phase sequencer for four roads, feeding the traffic light decoder.
// Supports demand-based road skipping, emergency pre-emption and an enable that forces lights off.
module traffic_phase_seq #(
    parameter int unsigned CLK_DIV      = 10,
    parameter int unsigned GREEN_TICKS  = 30,
    parameter int unsigned YELLOW_TICKS = 5,
    parameter int unsigned TW           = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] demand,
    input  logic       emg_req,
    input  logic [1:0] emg_road,
    output logic       i,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    output logic [1:0] cur_road,
    output logic       phase_done
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST  = PW'(CLK_DIV - 1);
    localparam logic [TW-1:0] GREEN_LAST  = TW'(GREEN_TICKS - 1);
    localparam logic [TW-1:0] YELLOW_LAST = TW'(YELLOW_TICKS - 1);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    road_q, road_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          i_q, i_d;
    logic [2:0]    code_q, code_d;
    logic          phase_done_q, phase_done_d;
    logic          tick;
    logic [1:0]    next_road;

    // First road after r (wrapping back to r itself) that has demand; plain rotation if none.
    function automatic logic [1:0] pick_next(input logic [1:0] r, input logic [3:0] dem);
        logic [1:0] n;
        logic [1:0] idx;
        logic       found;
        n     = r + 2'd1;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = r + 2'(k);
            if (!found && dem[idx]) begin
                n     = idx;
                found = 1'b1;
            end
        end
        return n;
    endfunction

    always_comb begin
        state_d      = state_q;
        road_d       = road_q;
        timer_d      = timer_q;
        presc_d      = presc_q;
        phase_done_d = 1'b0;
        tick         = (presc_q == PRESC_LAST);
        next_road    = emg_req ? emg_road : pick_next(road_q, demand);

        if (!en) begin
            state_d = ST_OFF;
            road_d  = 2'd0;
            timer_d = '0;
            presc_d = '0;
        end else begin
            unique case (state_q)
                ST_OFF: begin
                    state_d = ST_GREEN;
                    road_d  = 2'd0;
                    timer_d = '0;
                    presc_d = '0;
                end
                ST_GREEN: begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    // Emergency road already green: freeze so the full green restarts on release.
                    if (emg_req && (emg_road == road_q)) begin
                        timer_d = '0;
                        presc_d = '0;
                    end else if (tick) begin
                        if (emg_req || (timer_q == GREEN_LAST)) begin
                            state_d      = ST_YELLOW;
                            timer_d      = '0;
                            phase_done_d = 1'b1;
                        end else begin
                            timer_d = timer_q + TW'(1);
                        end
                    end
                end
                ST_YELLOW: begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (tick) begin
                        if (timer_q == YELLOW_LAST) begin
                            state_d      = ST_GREEN;
                            road_d       = next_road;
                            timer_d      = '0;
                            phase_done_d = 1'b1;
                        end else begin
                            timer_d = timer_q + TW'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    road_d  = 2'd0;
                    timer_d = '0;
                    presc_d = '0;
                end
            endcase
        end

        i_d    = (state_d != ST_OFF);
        code_d = {road_d, (state_d == ST_YELLOW)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_OFF;
            road_q       <= 2'd0;
            timer_q      <= '0;
            presc_q      <= '0;
            i_q          <= 1'b0;
            code_q       <= 3'd0;
            phase_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            road_q       <= road_d;
            timer_q      <= timer_d;
            presc_q      <= presc_d;
            i_q          <= i_d;
            code_q       <= code_d;
            phase_done_q <= phase_done_d;
        end
    end

    assign i          = i_q;
    assign s0         = code_q[2];
    assign s1         = code_q[1];
    assign s2         = code_q[0];
    assign cur_road   = road_q;
    assign phase_done = phase_done_q;

endmodule

// File: tb/tb_traffic_phase_seq.sv
// Directed self-checking bench for traffic_phase_seq with CLK_DIV=4, GREEN_TICKS=3, YELLOW_TICKS=2.
module tb_traffic_phase_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] demand;
    logic       emg_req;
    logic [1:0] emg_road;
    logic       i, s0, s1, s2, phase_done;
    logic [1:0] cur_road;

    int n_assert = 0;
    int n_fail   = 0;

    traffic_phase_seq #(
        .CLK_DIV(4), .GREEN_TICKS(3), .YELLOW_TICKS(2), .TW(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .demand(demand),
        .emg_req(emg_req), .emg_road(emg_road),
        .i(i), .s0(s0), .s1(s1), .s2(s2),
        .cur_road(cur_road), .phase_done(phase_done)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Observed vector is {i, code, phase_done, cur_road}.
    task automatic chk(input string tag, input logic ei, input logic [2:0] ecode,
                       input logic epd, input logic [1:0] eroad);
        logic [6:0] obs;
        logic [6:0] exp;
        obs = {i, s0, s1, s2, phase_done, cur_road};
        exp = {ei, ecode, epd, eroad};
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed={i,code,pd,road}=%b expected=%b", tag, obs, exp);
        end
    endtask

    // From one cycle into a phase: confirm it holds for len clk, then the new code with a pulse.
    task automatic phase(input string tag, input int len,
                         input logic [2:0] pcode, input logic [1:0] proad,
                         input logic [2:0] ncode, input logic [1:0] nroad);
        tick(len - 1);
        chk({tag, "_hold"}, 1'b1, pcode, 1'b0, proad);
        tick(1);
        chk({tag, "_next"}, 1'b1, ncode, 1'b1, nroad);
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b1;
        demand   = 4'b1111;
        emg_req  = 1'b0;
        emg_road = 2'd0;

        tick(3);
        chk("rst_hold", 1'b0, 3'b000, 1'b0, 2'd0);
        rst_n = 1'b1;
        tick(1);
        chk("en_on", 1'b1, 3'b000, 1'b0, 2'd0);

        // Full rotation with all roads demanding.
        phase("rot_g0", 12, 3'b000, 2'd0, 3'b001, 2'd0);
        phase("rot_y0",  8, 3'b001, 2'd0, 3'b010, 2'd1);
        phase("rot_g1", 12, 3'b010, 2'd1, 3'b011, 2'd1);
        phase("rot_y1",  8, 3'b011, 2'd1, 3'b100, 2'd2);
        phase("rot_g2", 12, 3'b100, 2'd2, 3'b101, 2'd2);
        phase("rot_y2",  8, 3'b101, 2'd2, 3'b110, 2'd3);
        phase("rot_g3", 12, 3'b110, 2'd3, 3'b111, 2'd3);
        phase("rot_y3",  8, 3'b111, 2'd3, 3'b000, 2'd0);

        // Only roads 0 and 2 demanding.
        demand = 4'b0101;
        phase("skip_g0", 12, 3'b000, 2'd0, 3'b001, 2'd0);
        phase("skip_y0",  8, 3'b001, 2'd0, 3'b100, 2'd2);
        phase("skip_g2", 12, 3'b100, 2'd2, 3'b101, 2'd2);
        phase("skip_y2",  8, 3'b101, 2'd2, 3'b000, 2'd0);

        // Emergency for road 3 while road 0 green at timer=1.
        tick(4);
        emg_req  = 1'b1;
        emg_road = 2'd3;
        tick(3);
        chk("trunc_wait", 1'b1, 3'b000, 1'b0, 2'd0);
        tick(1);
        chk("trunc", 1'b1, 3'b001, 1'b1, 2'd0);
        phase("emg_y", 8, 3'b001, 2'd0, 3'b110, 2'd3);
        tick(30);
        chk("emg_hold", 1'b1, 3'b110, 1'b0, 2'd3);
        emg_req = 1'b0;
        phase("emg_rel", 12, 3'b110, 2'd3, 3'b111, 2'd3);

        demand = 4'b1111;
        phase("post_y3", 8, 3'b111, 2'd3, 3'b000, 2'd0);
        phase("post_g0", 12, 3'b000, 2'd0, 3'b001, 2'd0);
        phase("post_y0",  8, 3'b001, 2'd0, 3'b010, 2'd1);
        phase("post_g1", 12, 3'b010, 2'd1, 3'b011, 2'd1);

        // Disable mid-yellow, then re-enable.
        tick(2);
        en = 1'b0;
        tick(1);
        chk("dis", 1'b0, 3'b000, 1'b0, 2'd0);
        tick(5);
        chk("dis_hold", 1'b0, 3'b000, 1'b0, 2'd0);
        en = 1'b1;
        tick(1);
        chk("reen", 1'b1, 3'b000, 1'b0, 2'd0);
        phase("reen_g0", 12, 3'b000, 2'd0, 3'b001, 2'd0);

        demand = 4'b0100;
        phase("r2_y0",  8, 3'b001, 2'd0, 3'b100, 2'd2);
        phase("r2_g2", 12, 3'b100, 2'd2, 3'b101, 2'd2);

        // Asynchronous reset between clock edges.
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst", 1'b0, 3'b000, 1'b0, 2'd0);
        #2;
        rst_n = 1'b1;
        tick(1);
        chk("post_rst", 1'b1, 3'b000, 1'b0, 2'd0);

        // No demand at all: plain rotation.
        demand = 4'b0000;
        phase("nodem_g0", 12, 3'b000, 2'd0, 3'b001, 2'd0);
        phase("nodem_y0",  8, 3'b001, 2'd0, 3'b010, 2'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
